// File: rtl/sysbus_pkg.sv
// Shared definitions for the system-bus memory responder: tag layout,
// request encodings, line geometry and the responder state type.
package sysbus_pkg;

  localparam int TAG_RW_BIT   = 12;
  localparam int TAG_TYPE_MSB = 11;
  localparam int TAG_TYPE_LSB = 8;

  localparam logic TAG_READ  = 1'b1;
  localparam logic TAG_WRITE = 1'b0;

  typedef enum logic [3:0] {
    TYPE_MEM = 4'h0,
    TYPE_IO  = 4'h1,
    TYPE_CFG = 4'h2,
    TYPE_DMA = 4'h3
  } req_type_t;

  localparam int BEATS_PER_LINE   = 8;
  localparam int BEAT_BITS        = 3;
  localparam int LINE_OFFSET_BITS = 6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_DATA  = 2'd1,
    RD_WAIT  = 2'd2,
    RD_BURST = 2'd3
  } state_t;

  // True when a request tag encodes a read.
  function automatic logic tag_is_read(input logic rw_bit);
    return (rw_bit == TAG_READ);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Backing store: single address port, synchronous write, asynchronous read.
module mem_array #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Word write; contents are never cleared so aborted writes keep their beats.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sysbus_mem_responder.sv
// Line-oriented memory responder: accepts 8-beat writes and answers 8-beat
// reads after a fixed latency, one transaction outstanding at a time.
module sysbus_mem_responder
  import sysbus_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 1024,
  parameter int READ_LATENCY   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bus_respack
);

  localparam int LINES   = MEM_WORDS / BEATS_PER_LINE;
  localparam int LINE_W  = $clog2(LINES);
  localparam int WORD_AW = $clog2(MEM_WORDS);

  localparam logic [3:0]           LAT_LAST  = 4'(READ_LATENCY - 1);
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS_PER_LINE - 1);

  state_t                     state;
  state_t                     state_nxt;
  logic [BEAT_BITS-1:0]       beat;
  logic [BEAT_BITS-1:0]       beat_nxt;
  logic [3:0]                 lat_cnt;
  logic [3:0]                 lat_nxt;
  logic [LINE_W-1:0]          line;
  logic [LINE_W-1:0]          line_nxt;
  logic [BUS_TAG_WIDTH-1:0]   tag;
  logic [BUS_TAG_WIDTH-1:0]   tag_nxt;
  logic                       reqack_c;
  logic                       wr_en_c;
  logic                       mem_we;
  logic [WORD_AW-1:0]         mem_addr;
  logic [BUS_DATA_WIDTH-1:0]  mem_rdata;

  // State, counters and latched request fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      beat    <= '0;
      lat_cnt <= '0;
      line    <= '0;
      tag     <= '0;
    end else begin
      state   <= state_nxt;
      beat    <= beat_nxt;
      lat_cnt <= lat_nxt;
      line    <= line_nxt;
      tag     <= tag_nxt;
    end
  end

  // Next-state, counter updates and request handshake.
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    lat_nxt   = lat_cnt;
    line_nxt  = line;
    tag_nxt   = tag;
    reqack_c  = 1'b0;
    wr_en_c   = 1'b0;
    case (state)
      IDLE: begin
        if (bus_reqcyc) begin
          reqack_c = 1'b1;
          line_nxt = bus_req[LINE_OFFSET_BITS +: LINE_W];
          tag_nxt  = bus_reqtag;
          beat_nxt = '0;
          lat_nxt  = '0;
          if (tag_is_read(bus_reqtag[TAG_RW_BIT])) begin
            state_nxt = RD_WAIT;
          end else begin
            state_nxt = WR_DATA;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      WR_DATA: begin
        if (bus_reqcyc) begin
          reqack_c = 1'b1;
          wr_en_c  = 1'b1;
          if (beat == LAST_BEAT) begin
            beat_nxt  = '0;
            state_nxt = IDLE;
          end else begin
            beat_nxt = beat + 3'd1;
          end
        end else begin
          state_nxt = WR_DATA;
        end
      end
      RD_WAIT: begin
        if (lat_cnt == LAT_LAST) begin
          lat_nxt   = '0;
          beat_nxt  = '0;
          state_nxt = RD_BURST;
        end else begin
          lat_nxt = lat_cnt + 4'd1;
        end
      end
      RD_BURST: begin
        if (bus_respack) begin
          if (beat == LAST_BEAT) begin
            beat_nxt  = '0;
            state_nxt = IDLE;
          end else begin
            beat_nxt = beat + 3'd1;
          end
        end else begin
          state_nxt = RD_BURST;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Reset masks the handshakes immediately so nothing leaks during the reset cycle.
  assign bus_reqack  = reqack_c & ~reset;
  assign mem_we      = wr_en_c & ~reset;
  assign mem_addr    = {line, beat};
  assign bus_respcyc = (state == RD_BURST) & ~reset;
  assign bus_resp    = bus_respcyc ? mem_rdata : '0;
  assign bus_resptag = bus_respcyc ? tag : '0;

  mem_array #(
    .WIDTH (BUS_DATA_WIDTH),
    .DEPTH (MEM_WORDS)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (bus_req),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Scoreboard bench for sysbus_mem_responder: randomized line traffic checked
// against a word-array model of the backing store.
module tb_sysbus_mem_responder;

  localparam int DW    = 64;
  localparam int TW    = 13;
  localparam int WORDS = 1024;
  localparam int LAT   = 4;
  localparam int LINES = WORDS / 8;

  logic          clk;
  logic          reset;
  logic          bus_reqcyc;
  logic [DW-1:0] bus_req;
  logic [TW-1:0] bus_reqtag;
  logic          bus_reqack;
  logic          bus_respcyc;
  logic [DW-1:0] bus_resp;
  logic [TW-1:0] bus_resptag;
  logic          bus_respack;

  sysbus_mem_responder #(
    .BUS_DATA_WIDTH (DW),
    .BUS_TAG_WIDTH  (TW),
    .MEM_WORDS      (WORDS),
    .READ_LATENCY   (LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus_reqcyc  (bus_reqcyc),
    .bus_req     (bus_req),
    .bus_reqtag  (bus_reqtag),
    .bus_reqack  (bus_reqack),
    .bus_respcyc (bus_respcyc),
    .bus_resp    (bus_resp),
    .bus_resptag (bus_resptag),
    .bus_respack (bus_respack)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    bit            first;
    int            cyc;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model [WORDS];
  logic [DW-1:0] wbuf [8];
  int            wgap [8];
  int            total = 0;
  int            bad = 0;
  int            cycle = 0;
  int            ack_mode = 0;
  int            ack_idx = 0;
  bit            first_seen = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cycle++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic int line_of(input logic [63:0] addr);
    return int'((addr >> 6) % 64'(LINES));
  endfunction

  // Monitor: compares every presented beat with the scoreboard head and acks.
  initial begin
    bit   a;
    exp_t e;
    bus_respack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_respcyc) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_beat", bus_resp, 64'h0);
          bus_respack = 1'b1;
        end else begin
          e = exp_q[0];
          check(bus_resp == e.data, "resp_data", bus_resp, e.data);
          check(bus_resptag == e.tag, "resp_tag", 64'(bus_resptag), 64'(e.tag));
          if (e.first && !first_seen) begin
            check(cycle == e.cyc, "first_beat_latency", 64'(cycle), 64'(e.cyc));
          end
          first_seen = 1'b1;
          case (ack_mode)
            0:       a = 1'b1;
            1:       a = ((ack_idx % 3) == 0);
            2:       a = 1'($urandom_range(0, 1));
            default: a = 1'b0;
          endcase
          ack_idx++;
          bus_respack = a;
          if (a) begin
            void'(exp_q.pop_front());
            first_seen = 1'b0;
          end
        end
      end else begin
        check(bus_resp == '0 && bus_resptag == '0, "idle_zero", bus_resp | 64'(bus_resptag), 64'h0);
        bus_respack = 1'($urandom_range(0, 1));
        first_seen = 1'b0;
      end
    end
  end

  // Drive one request beat from just after a posedge until it is accepted.
  task automatic send_beat(input logic [DW-1:0] d, input logic [TW-1:0] t, output int acc);
    int n = 0;
    bus_reqcyc = 1'b1;
    bus_req    = d;
    bus_reqtag = t;
    @(negedge clk);
    while (!bus_reqack && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus_reqack) check(1'b0, "accept_timeout", 64'(n), 64'h0);
    acc = cycle;
    @(posedge clk);
    #1;
    bus_reqcyc = 1'b0;
    bus_req    = '0;
    bus_reqtag = '0;
  endtask

  task automatic write_beats(input int ln, input logic [TW-1:0] t);
    int acc;
    for (int b = 0; b < 8; b++) begin
      repeat (wgap[b]) begin
        @(posedge clk);
        #1;
      end
      send_beat(wbuf[b], t, acc);
      model[ln * 8 + b] = wbuf[b];
    end
  endtask

  task automatic do_write(input logic [63:0] addr);
    int            acc;
    logic [TW-1:0] t;
    t = {1'b0, 4'($urandom_range(0, 3)), 8'($urandom)};
    send_beat(addr, t, acc);
    write_beats(line_of(addr), t);
  endtask

  task automatic do_read(input logic [63:0] addr, output int acc);
    logic [TW-1:0] t;
    exp_t          e;
    int            ln;
    t  = {1'b1, 4'($urandom_range(0, 3)), 8'($urandom)};
    ln = line_of(addr);
    send_beat(addr, t, acc);
    for (int b = 0; b < 8; b++) begin
      e.data  = model[ln * 8 + b];
      e.tag   = t;
      e.first = (b == 0);
      e.cyc   = acc + LAT + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check(exp_q.size() == 0, "drain", 64'(exp_q.size()), 64'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic read_and_drain(input logic [63:0] addr);
    int acc;
    do_read(addr, acc);
    drain();
  endtask

  initial begin
    int            acc;
    int            n;
    logic [63:0]   a;

    reset      = 1'b1;
    bus_reqcyc = 1'b1;
    bus_req    = 64'h1000;
    bus_reqtag = 13'h0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check(bus_reqack == 1'b0, "reset_reqack", 64'(bus_reqack), 64'h0);
      check(bus_respcyc == 1'b0, "reset_respcyc", 64'(bus_respcyc), 64'h0);
    end
    @(posedge clk);
    #1;
    reset      = 1'b0;
    bus_reqcyc = 1'b0;
    bus_req    = '0;
    @(negedge clk);
    check(bus_reqack == 1'b0, "post_reset_reqack", 64'(bus_reqack), 64'h0);
    @(posedge clk);
    #1;

    // Give every line defined contents.
    for (int l = 0; l < LINES; l++) begin
      for (int b = 0; b < 8; b++) begin
        wbuf[b] = {$urandom, $urandom};
        wgap[b] = 0;
      end
      do_write(64'(l) << 6);
    end

    // Known pattern at 0x1000, then linear readback with fixed latency.
    for (int b = 0; b < 8; b++) begin
      wbuf[b] = 64'h11 * 64'(b + 1);
      wgap[b] = 0;
    end
    do_write(64'h1000);
    ack_mode = 0;
    read_and_drain(64'h1000);

    // Stalling initiator: ack pattern 1,0,0,...
    ack_mode = 1;
    ack_idx  = 0;
    read_and_drain(64'h1000);

    // Offset bits and high address bits alias onto the same line.
    ack_mode = 2;
    read_and_drain(64'h1008);
    read_and_drain(64'h103F);
    read_and_drain(64'(WORDS * 8) + 64'h1000);

    // A request held during a read burst is only accepted back in IDLE.
    ack_mode = 0;
    do_read(64'h1000, acc);
    bus_reqcyc = 1'b1;
    bus_req    = 64'h1400;
    bus_reqtag = 13'h0155;
    n = 0;
    @(negedge clk);
    while (!bus_reqack && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(cycle == acc + LAT + 9, "held_req_accept_cycle", 64'(cycle), 64'(acc + LAT + 9));
    check(exp_q.size() == 0, "held_req_after_burst", 64'(exp_q.size()), 64'h0);
    @(posedge clk);
    #1;
    bus_reqcyc = 1'b0;
    for (int b = 0; b < 8; b++) begin
      wbuf[b] = {$urandom, $urandom};
      wgap[b] = 0;
    end
    write_beats(line_of(64'h1400), 13'h0155);
    read_and_drain(64'h1400);

    // Reset while beat 3 of a read is presented.
    ack_mode = 0;
    do_read(64'h1000, acc);
    n = 0;
    while (exp_q.size() > 5 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    ack_mode = 3;
    @(negedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check(bus_respcyc == 1'b0, "reset_abort_respcyc", 64'(bus_respcyc), 64'h0);
    @(posedge clk);
    #1;
    ack_mode = 0;
    read_and_drain(64'h1000);

    // Write with stalls before beats 2 and 5.
    for (int b = 0; b < 8; b++) begin
      wbuf[b] = {$urandom, $urandom};
      wgap[b] = (b == 2 || b == 5) ? 3 : 0;
    end
    do_write(64'h2400);
    ack_mode = 2;
    read_and_drain(64'h2400);

    // Random mix of reads and writes anywhere in the address space.
    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) begin
        read_and_drain(a);
      end else begin
        for (int b = 0; b < 8; b++) begin
          wbuf[b] = {$urandom, $urandom};
          wgap[b] = $urandom_range(0, 2);
        end
        do_write(a);
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
